// File: rtl/spectrum_bar_smoother.sv
// Log-scaled spectrum bar smoother: turns 16 FFT bins into bar heights with
// instant attack, one-step decay, and a peak marker that holds and then falls.
module spectrum_bar_smoother #(
  parameter int NOISE_FLOOR = 4,
  parameter int HOLD_FRAMES = 8,
  parameter int HOLD_W      = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [15:0][15:0] i_data,
  input  logic              i_data_done,
  output logic [15:0][3:0]  o_bar,
  output logic [15:0][3:0]  o_peak,
  output logic              o_valid,
  output logic              o_busy,
  output logic [7:0]        o_drop_cnt
);

  localparam logic [3:0]        NF   = 4'(NOISE_FLOOR);
  localparam logic [HOLD_W-1:0] HOLD = HOLD_W'(HOLD_FRAMES);

  typedef enum logic [1:0] {S_IDLE, S_PROC, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [15:0][15:0]        shadow_q, shadow_d;
  logic [3:0]               bin_idx_q, bin_idx_d;
  logic [15:0][3:0]         bar_w_q, bar_w_d;
  logic [15:0][3:0]         peak_w_q, peak_w_d;
  logic [15:0][HOLD_W-1:0]  hold_q, hold_d;
  logic [15:0][3:0]         bar_q, bar_d;
  logic [15:0][3:0]         peak_q, peak_d;
  logic                     valid_q, valid_d;
  logic [7:0]               drop_q, drop_d;

  logic [15:0]       cur_x;
  logic [15:0]       neg_x;
  logic [14:0]       mag;
  logic [3:0]        lvl;
  logic [3:0]        tgt;
  logic [3:0]        cur_bar, cur_peak;
  logic [HOLD_W-1:0] cur_hold;
  logic [3:0]        bar_n, peak_n;
  logic [HOLD_W-1:0] hold_n;

  // Per-bin arithmetic for the bin selected by bin_idx_q.
  always_comb begin
    cur_x    = shadow_q[bin_idx_q];
    cur_bar  = bar_w_q[bin_idx_q];
    cur_peak = peak_w_q[bin_idx_q];
    cur_hold = hold_q[bin_idx_q];
    neg_x    = 16'(~cur_x + 16'd1);

    if (!cur_x[15])
      mag = cur_x[14:0];
    else if (cur_x == 16'h8000)
      mag = 15'h7FFF;
    else
      mag = neg_x[14:0];

    lvl = 4'd0;
    for (int i = 0; i < 15; i++) begin
      if (mag[i]) lvl = 4'(i + 1);
    end

    tgt   = (lvl > NF) ? lvl - NF : 4'd0;
    bar_n = (tgt >= cur_bar) ? tgt : cur_bar - 4'd1;

    if (bar_n >= cur_peak) begin
      peak_n = bar_n;
      hold_n = HOLD;
    end else if (cur_hold != '0) begin
      peak_n = cur_peak;
      hold_n = cur_hold - HOLD_W'(1);
    end else begin
      peak_n = cur_peak - 4'd1;
      hold_n = '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    bin_idx_d = bin_idx_q;
    bar_w_d   = bar_w_q;
    peak_w_d  = peak_w_q;
    hold_d    = hold_q;
    bar_d     = bar_q;
    peak_d    = peak_q;
    valid_d   = 1'b0;
    drop_d    = drop_q;

    // A done pulse anywhere outside S_IDLE is dropped, including S_DONE.
    if (i_data_done && (state_q != S_IDLE) && (drop_q != 8'hFF))
      drop_d = drop_q + 8'd1;

    case (state_q)
      S_IDLE: begin
        if (i_data_done) begin
          shadow_d  = i_data;
          bin_idx_d = 4'd0;
          state_d   = S_PROC;
        end
      end
      S_PROC: begin
        bar_w_d[bin_idx_q]  = bar_n;
        peak_w_d[bin_idx_q] = peak_n;
        hold_d[bin_idx_q]   = hold_n;
        bin_idx_d           = bin_idx_q + 4'd1;
        if (bin_idx_q == 4'd15) state_d = S_DONE;
      end
      S_DONE: begin
        bar_d   = bar_w_q;
        peak_d  = peak_w_q;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      shadow_q  <= '0;
      bin_idx_q <= '0;
      bar_w_q   <= '0;
      peak_w_q  <= '0;
      hold_q    <= '0;
      bar_q     <= '0;
      peak_q    <= '0;
      valid_q   <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      bin_idx_q <= bin_idx_d;
      bar_w_q   <= bar_w_d;
      peak_w_q  <= peak_w_d;
      hold_q    <= hold_d;
      bar_q     <= bar_d;
      peak_q    <= peak_d;
      valid_q   <= valid_d;
      drop_q    <= drop_d;
    end
  end

  assign o_bar      = bar_q;
  assign o_peak     = peak_q;
  assign o_valid    = valid_q;
  assign o_busy     = (state_q != S_IDLE);
  assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_spectrum_bar_smoother.sv
// Directed + randomized bench for spectrum_bar_smoother against a per-frame
// arithmetic reference model.
module tb_spectrum_bar_smoother;

  logic              clk;
  logic              i_rst;
  logic [15:0][15:0] i_data;
  logic              i_data_done;
  logic [15:0][3:0]  o_bar;
  logic [15:0][3:0]  o_peak;
  logic              o_valid;
  logic              o_busy;
  logic [7:0]        o_drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  int m_bar[16];
  int m_peak[16];
  int m_hold[16];
  int m_drop;

  spectrum_bar_smoother #(.NOISE_FLOOR(4), .HOLD_FRAMES(8), .HOLD_W(4)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_data     (i_data),
    .i_data_done(i_data_done),
    .o_bar      (o_bar),
    .o_peak     (o_peak),
    .o_valid    (o_valid),
    .o_busy     (o_busy),
    .o_drop_cnt (o_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] pack(input int a[16]);
    logic [15:0][3:0] r;
    for (int k = 0; k < 16; k++) r[k] = 4'(a[k]);
    return r;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 16; k++) begin
      m_bar[k] = 0; m_peak[k] = 0; m_hold[k] = 0;
    end
    m_drop = 0;
  endfunction

  // Frame update computed straight from the log2 / smoothing rules.
  function automatic void model_frame(input logic [15:0][15:0] d);
    int x, mag, lvl, tgt, bn;
    for (int k = 0; k < 16; k++) begin
      x   = int'($signed(d[k]));
      mag = (x < 0) ? -x : x;
      if (mag > 32767) mag = 32767;
      lvl = (mag == 0) ? 0 : $clog2(mag + 1);
      tgt = (lvl > 4) ? lvl - 4 : 0;
      bn  = (tgt >= m_bar[k]) ? tgt : m_bar[k] - 1;
      if (bn >= m_peak[k]) begin
        m_peak[k] = bn; m_hold[k] = 8;
      end else if (m_hold[k] != 0) begin
        m_hold[k] = m_hold[k] - 1;
      end else begin
        m_peak[k] = m_peak[k] - 1;
      end
      m_bar[k] = bn;
    end
  endfunction

  function automatic logic [15:0][15:0] rand_frame();
    logic [15:0][15:0] d;
    for (int k = 0; k < 16; k++) begin
      case ($urandom_range(0, 5))
        0: d[k] = 16'h0000;
        1: d[k] = 16'h8000;
        default: begin
          d[k] = 16'($urandom >> (16 + $urandom_range(0, 16)));
          if ($urandom_range(0, 1) == 1) d[k] = 16'(-d[k]);
        end
      endcase
    end
    return d;
  endfunction

  task automatic run_frame(input logic [15:0][15:0] d, input int drop_at, input string tag);
    logic [63:0] old_bar, old_peak;
    bit          got;
    int          lat;
    bit          ok;
    old_bar  = pack(m_bar);
    old_peak = pack(m_peak);
    @(posedge clk); #1;
    i_data = d; i_data_done = 1'b1;
    @(posedge clk); #1;
    i_data_done = 1'b0;
    i_data = rand_frame();
    model_frame(d);
    got = 0; lat = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      i_data_done = 1'b0;
      if (o_valid) begin
        got = 1; lat = cyc;
        break;
      end
      if (cyc == drop_at) begin
        i_data_done = 1'b1;
        if (m_drop < 255) m_drop++;
      end
      if (cyc == 8) begin
        check({tag, " busy"}, 64'(o_busy), 64'd1);
        check({tag, " bar_stable"}, o_bar, old_bar);
        check({tag, " peak_stable"}, o_peak, old_peak);
      end
    end
    check({tag, " valid_seen"}, 64'(got), 64'd1);
    check({tag, " latency"}, 64'(lat), 64'd17);
    check({tag, " bar"}, o_bar, pack(m_bar));
    check({tag, " peak"}, o_peak, pack(m_peak));
    check({tag, " drop"}, 64'(o_drop_cnt), 64'(m_drop));
    ok = 1;
    for (int k = 0; k < 16; k++) if (o_peak[k] < o_bar[k]) ok = 0;
    check({tag, " peak_ge_bar"}, 64'(ok), 64'd1);
    @(posedge clk); #1;
    check({tag, " valid_one_cycle"}, 64'(o_valid), 64'd0);
    check({tag, " idle_after"}, 64'(o_busy), 64'd0);
  endtask

  initial begin
    logic [15:0][15:0] d;
    logic [15:0][15:0] zero;
    bit                saw_valid;

    zero = '0;
    i_rst = 1'b1; i_data = '0; i_data_done = 1'b0;
    model_reset();

    // reset
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
    check("rst bar", o_bar, 64'd0);
    check("rst peak", o_peak, 64'd0);
    check("rst valid", 64'(o_valid), 64'd0);
    check("rst busy", 64'(o_busy), 64'd0);
    check("rst drop", 64'(o_drop_cnt), 64'd0);

    // log mapping
    d = '0;
    d[0] = 16'h0001; d[1] = 16'hFFF0; d[2] = 16'h7FFF; d[3] = 16'h8000;
    run_frame(d, 0, "map");
    check("map bar0", 64'(o_bar[0]), 64'd0);
    check("map bar1", 64'(o_bar[1]), 64'd1);
    check("map bar2", 64'(o_bar[2]), 64'd11);
    check("map bar3", 64'(o_bar[3]), 64'd11);

    // decay and peak hold
    for (int j = 1; j <= 11; j++) begin
      run_frame(zero, 0, "decay");
      check("decay bar2", 64'(o_bar[2]), 64'(11 - j));
      check("decay peak2", 64'(o_peak[2]), 64'((j <= 8) ? 11 : 11 - (j - 8)));
    end

    // attack reloads hold
    d = '0; d[2] = 16'h7FFF;
    run_frame(d, 0, "attack");
    check("attack bar2", 64'(o_bar[2]), 64'd11);
    check("attack peak2", 64'(o_peak[2]), 64'd11);
    for (int j = 1; j <= 9; j++) run_frame(zero, 0, "hold");
    check("hold peak2", 64'(o_peak[2]), 64'd10);

    // overrun at 5 cycles after acceptance, and in S_DONE
    run_frame(rand_frame(), 4, "overrun");
    run_frame(rand_frame(), 16, "drop_sdone");

    // random frames with occasional overruns
    for (int j = 0; j < 25; j++) begin
      case ($urandom_range(0, 3))
        0: run_frame(rand_frame(), $urandom_range(1, 16), "rand_drop");
        1: run_frame(zero, 0, "rand_zero");
        default: run_frame(rand_frame(), 0, "rand");
      endcase
    end

    // drop counter saturation
    @(posedge clk); #1;
    i_data = rand_frame(); i_data_done = 1'b1;
    repeat (400) @(posedge clk);
    #1;
    i_data_done = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("sat drop", 64'(o_drop_cnt), 64'd255);
    check("sat idle", 64'(o_busy), 64'd0);

    // reset mid-frame
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    model_reset();
    d = '0;
    d[0] = 16'h0001; d[1] = 16'hFFF0; d[2] = 16'h7FFF; d[3] = 16'h8000;
    run_frame(d, 3, "pre_abort");
    @(posedge clk); #1;
    i_data = rand_frame(); i_data_done = 1'b1;
    @(posedge clk); #1;
    i_data_done = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    model_reset();
    check("abort bar", o_bar, 64'd0);
    check("abort peak", o_peak, 64'd0);
    check("abort busy", 64'(o_busy), 64'd0);
    check("abort drop", 64'(o_drop_cnt), 64'd0);
    saw_valid = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (o_valid) saw_valid = 1;
    end
    check("abort no_valid", 64'(saw_valid), 64'd0);
    d = '0; d[5] = 16'h0100;
    run_frame(d, 0, "post_abort");
    check("post_abort bar5", 64'(o_bar[5]), 64'd5);
    check("post_abort bar2", 64'(o_bar[2]), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
